// File: rtl/pow_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pow_pkg
// Purpose : Shared widths, FSM state encoding and request record for the
//           exponentiator dispatcher.
// Rev     : 1.0  initial release
// ============================================================================
package pow_pkg;

    localparam int X_W     = 16;
    localparam int N_W     = 8;
    localparam int C_TAG_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_BUSY   = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [N_W-1:0]     n;
        logic [C_TAG_W-1:0] tag;
    } req_t;

endpackage
`default_nettype wire

// File: rtl/req_fifo.sv
`default_nettype none
// ============================================================================
// Module  : req_fifo
// Purpose : Power-of-two circular request queue; occupancy count is the only
//           full/empty discriminator, pointers wrap naturally.
// Rev     : 1.0  initial release
// ============================================================================
module req_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  T                       i_data,
    output T                       o_head,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int               PTR_W  = $clog2(DEPTH);
    localparam logic [PTR_W:0]   C_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   C_ZERO = '0;

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_level;
    logic             w_push;
    logic             w_pop;

    // Guard locally so a misbehaving parent cannot corrupt the count.
    assign w_push = i_push && (r_level != C_FULL);
    assign w_pop  = i_pop  && (r_level != C_ZERO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_level = r_level;
    assign o_full  = (r_level == C_FULL);
    assign o_empty = (r_level == C_ZERO);

endmodule
`default_nettype wire

// File: rtl/pow_dispatcher.sv
`default_nettype none
// ============================================================================
// Module  : pow_dispatcher
// Purpose : Queues tagged x^n requests and feeds them one at a time to a
//           start/ready exponentiator, returning results in request order.
// Rev     : 1.0  initial release
// ============================================================================
module pow_dispatcher
    import pow_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [X_W-1:0]         in_x,
    input  logic [N_W-1:0]         in_n,
    output logic                   pw_start,
    output logic [X_W-1:0]         pw_x,
    output logic [N_W-1:0]         pw_n,
    input  logic                   pw_ready,
    input  logic [X_W-1:0]         pw_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [X_W-1:0]         res_data,
    output logic [TAG_W-1:0]       res_tag,
    output logic [$clog2(DEPTH):0] level
);

    state_t           r_state;
    state_t           w_next_state;
    logic [TAG_W-1:0] r_tag_cnt;
    logic [TAG_W-1:0] r_tag_inflight;
    logic [X_W-1:0]   r_res_data;
    logic [TAG_W-1:0] r_res_tag;

    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_start;
    logic             w_res_valid;
    req_t             w_push_req;
    req_t             w_head;

    assign in_ready   = !w_full;
    assign w_push     = in_valid && in_ready;
    assign w_push_req = '{x: in_x, n: in_n, tag: C_TAG_W'(r_tag_cnt)};

    req_fifo #(
        .DEPTH (DEPTH),
        .T     (req_t)
    ) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_req),
        .o_head  (w_head),
        .o_level (level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (!w_empty && pw_ready) w_next_state = ST_ISSUE;
            ST_ISSUE:  w_next_state = ST_SETTLE;
            // Exponentiator ready is stale for one cycle after start.
            ST_SETTLE: w_next_state = ST_BUSY;
            ST_BUSY:   if (pw_ready) w_next_state = ST_HOLD;
            ST_HOLD:   if (res_ready) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_start     = 1'b0;
        w_pop       = 1'b0;
        w_res_valid = 1'b0;
        case (r_state)
            ST_ISSUE: begin
                w_start = 1'b1;
                w_pop   = 1'b1;
            end
            ST_HOLD:  w_res_valid = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_cnt      <= '0;
            r_tag_inflight <= '0;
            r_res_data     <= '0;
            r_res_tag      <= '0;
        end else begin
            if (w_push) begin
                r_tag_cnt <= r_tag_cnt + 1'b1;
            end
            if (r_state == ST_ISSUE) begin
                r_tag_inflight <= TAG_W'(w_head.tag);
            end
            if ((r_state == ST_BUSY) && pw_ready) begin
                r_res_data <= pw_out;
                r_res_tag  <= r_tag_inflight;
            end
        end
    end

    assign pw_start  = w_start;
    assign pw_x      = w_head.x;
    assign pw_n      = w_head.n;
    assign res_valid = w_res_valid;
    assign res_data  = r_res_data;
    assign res_tag   = r_res_tag;

endmodule
`default_nettype wire

// File: tb/tb_pow_dispatcher.sv
`default_nettype none
// ============================================================================
// Module  : tb_pow_dispatcher
// Purpose : Scoreboard bench for pow_dispatcher driving a behavioural
//           start/ready exponentiator.
// Rev     : 1.0  initial release
// ============================================================================
module tb_pow_dispatcher;

    localparam int DEPTH = 4;
    localparam int TAG_W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [7:0]  in_n;
    logic        pw_start;
    logic [15:0] pw_x;
    logic [7:0]  pw_n;
    logic        pw_ready;
    logic [15:0] pw_out;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [7:0]  res_tag;
    logic [2:0]  level;

    always #5 clk = ~clk;

    pow_dispatcher #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_n(in_n),
        .pw_start(pw_start), .pw_x(pw_x), .pw_n(pw_n),
        .pw_ready(pw_ready), .pw_out(pw_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_tag(res_tag), .level(level)
    );

    // Behavioural exponentiator: ready drops after start, result after 4..11 cycles.
    function automatic logic [15:0] pow16(input logic [15:0] x, input logic [7:0] n);
        logic [15:0] r;
        r = 16'd1;
        for (int i = 0; i < int'(n); i++) r = r * x;
        return r;
    endfunction

    logic [15:0] ex_res;
    int          ex_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pw_ready <= 1'b1;
            pw_out   <= 16'd0;
            ex_res   <= 16'd0;
            ex_cnt   <= 0;
        end else if (pw_start && pw_ready) begin
            pw_ready <= 1'b0;
            pw_out   <= 16'hBAD0;
            ex_res   <= pow16(pw_x, pw_n);
            ex_cnt   <= 4 + int'(pw_n & 8'd7);
        end else if (!pw_ready) begin
            if (ex_cnt == 0) begin
                pw_ready <= 1'b1;
                pw_out   <= ex_res;
            end else begin
                ex_cnt <= ex_cnt - 1;
            end
        end
    end

    typedef struct {
        logic [15:0] d;
        logic [7:0]  t;
    } exp_t;

    exp_t       q[$];
    int         checks    = 0;
    int         errors    = 0;
    int         pw_starts = 0;
    int         results   = 0;
    logic [7:0] tb_tag    = 8'd0;
    logic [7:0] last_tag  = 8'hFF;

    always @(negedge clk) begin
        if (!rst) begin
            if (pw_start) pw_starts++;
            if (res_valid && res_ready) begin
                exp_t e;
                checks++;
                results++;
                last_tag = res_tag;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result got data=%0d tag=%0d, want no result", res_data, res_tag);
                end else begin
                    e = q.pop_front();
                    if (res_data !== e.d || res_tag !== e.t) begin
                        errors++;
                        $display("FAIL result got data=%0d tag=%0d, want data=%0d tag=%0d",
                                 res_data, res_tag, e.d, e.t);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic push(input logic [15:0] x, input logic [7:0] n, input logic [15:0] want);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout got in_ready=0 want 1 (x=%0d n=%0d)", x, n);
            return;
        end
        in_valid = 1'b1;
        in_x     = x;
        in_n     = n;
        @(posedge clk);
        q.push_back('{d: want, t: tb_tag});
        tb_tag++;
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((q.size() != 0 || level != 3'd0) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_drain_pending"}, 32'(q.size()) + 32'(level), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        tb_tag = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    logic [15:0] full_x   [6] = '{16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15};
    logic [15:0] full_exp [6] = '{16'd100, 16'd121, 16'd144, 16'd169, 16'd196, 16'd225};

    initial begin
        int          s;
        int          t;
        int          r0;
        logic [15:0] hd;
        logic [7:0]  ht;
        logic [15:0] w;

        in_valid  = 1'b0;
        in_x      = 16'd0;
        in_n      = 8'd0;
        res_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_pw_start",  pw_start,  0);
        chk("rst_level",     level,     0);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_res_data",  res_data,  0);
        chk("rst_res_tag",   res_tag,   0);
        rst = 1'b0;
        @(negedge clk);

        // Single request with start latency
        s = pw_starts;
        push(16'd3, 8'd4, 16'd81);
        @(negedge clk);
        chk("latency_edge1_start", pw_start, 0);
        @(negedge clk);
        chk("latency_edge2_start", pw_start, 1);
        chk("issue_pw_x", pw_x, 3);
        chk("issue_pw_n", pw_n, 4);
        drain("single");
        chk("single_start_count", 32'(pw_starts - s), 1);

        // Boundary exponents, tags 0..3
        do_reset();
        push(16'd2, 8'd0,  16'd1);
        push(16'd2, 8'd15, 16'd32768);
        push(16'd2, 8'd16, 16'd0);
        push(16'd0, 8'd0,  16'd1);
        drain("boundary");
        chk("boundary_last_tag", last_tag, 3);

        // Full FIFO with the consumer stalled
        do_reset();
        res_ready = 1'b0;
        s = pw_starts;
        fork
            begin
                for (int i = 0; i < 6; i++) push(full_x[i], 8'd2, full_exp[i]);
            end
        join_none
        t = 0;
        while (level != 3'd4 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("full_level", level, 4);
        chk("full_in_ready", in_ready, 0);
        repeat (10) @(negedge clk);
        chk("full_level_held", level, 4);
        chk("full_in_ready_held", in_ready, 0);
        chk("full_one_outstanding", 32'(pw_starts - s), 1);
        chk("full_res_valid", res_valid, 1);
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        drain("full");
        chk("full_start_count", 32'(pw_starts - s), 6);

        // Back-pressure in HOLD with another request queued
        res_ready = 1'b0;
        push(16'd9, 8'd2, 16'd81);
        push(16'd4, 8'd3, 16'd64);
        t = 0;
        while (!res_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("bp_res_valid", res_valid, 1);
        hd = res_data;
        ht = res_tag;
        chk("bp_first_data", hd, 81);
        chk("bp_first_tag", ht, 6);
        s = pw_starts;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_hold_data", res_data, hd);
            chk("bp_hold_tag", res_tag, ht);
        end
        chk("bp_no_start", 32'(pw_starts - s), 0);
        chk("bp_queue_level", level, 1);
        res_ready = 1'b1;
        drain("bp");

        // Reset while the exponentiator is busy
        push(16'd7, 8'd200, 16'd0);
        t = 0;
        while (!pw_start && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("busy_saw_start", pw_start, 1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("busy_pw_ready_low", pw_ready, 0);
        #1 rst = 1'b1;
        q.delete();
        tb_tag = 8'd0;
        #1;
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_pw_start",  pw_start,  0);
        chk("midrst_level",     level,     0);
        chk("midrst_in_ready",  in_ready,  1);
        chk("midrst_res_data",  res_data,  0);
        chk("midrst_res_tag",   res_tag,   0);
        @(negedge clk);
        rst = 1'b0;
        push(16'd5, 8'd3, 16'd125);
        drain("after_reset");
        chk("after_reset_tag", last_tag, 0);

        // Tag wrap over 257 requests
        do_reset();
        r0 = results;
        for (int k = 0; k < 257; k++) begin
            w = 16'd1 << (k % 16);
            push(16'd2, 8'(k % 16), w);
        end
        drain("wrap");
        chk("wrap_result_count", 32'(results - r0), 257);
        chk("wrap_last_tag", last_tag, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pow_dispatcher.md
POW_DISPATCHER -- requirements
Module: pow_dispatcher

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the request FIFO depth (power of two, ≥2).
REQ-002 SHALL have parameter TAG_W, default 8, the request tag width.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  FIFO can accept a request.
REQ-007 in_x  input  16  base.
REQ-008 in_n  input  8  exponent.
REQ-009 pw_start  output  1  start pulse to the exponentiator.
REQ-010 pw_x  output  16  base to the exponentiator.
REQ-011 pw_n  output  8  exponent to the exponentiator.
REQ-012 pw_ready  input  1  exponentiator idle/result valid.
REQ-013 pw_out  input  16  exponentiator result.
REQ-014 res_valid  output  1  result held.
REQ-015 res_ready  input  1  consumer accepts the result.
REQ-016 res_data  output  16  result, x^n mod 2^16.
REQ-017 res_tag  output  TAG_W  tag of the request that produced res_data.
REQ-018 level  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-019 Push: in_valid&in_ready at an edge SHALL write {in_x, in_n, tag_cnt} and increment tag_cnt (mod 2^TAG_W, wraps 255->0).
REQ-020 in_ready SHALL equal (level<DEPTH), decoded from registered state only; a full FIFO SHALL NOT accept a push even in a pop cycle.
REQ-021 FSM states: IDLE, ISSUE, SETTLE, BUSY, HOLD.
REQ-022 IDLE->ISSUE when level>0 and pw_ready=1; otherwise stay.
REQ-023 ISSUE: pw_start=1 for exactly one cycle, pw_x/pw_n = FIFO head; pop the head at the end of that cycle; ->SETTLE.
REQ-024 SETTLE: one cycle that ignores pw_ready (the exponentiator drops ready the cycle after start); ->BUSY.
REQ-025 BUSY: on pw_ready=1, capture pw_out into res_data and the popped tag into res_tag, set res_valid; ->HOLD.
REQ-026 HOLD: res_valid=1, res_data/res_tag stable; on res_ready=1 clear res_valid and ->IDLE.
REQ-027 pw_start SHALL be 0 in every state except ISSUE; pw_x/pw_n SHALL always show the FIFO head (don't-care when empty).
REQ-028 Latency: a push into an empty FIFO in the IDLE state SHALL produce pw_start two edges later (first edge pushes, second edge enters ISSUE).
REQ-029 Results SHALL leave in request order; at most one request is outstanding at the exponentiator.
REQ-030 Pushes SHALL be accepted in every FSM state; a push and a pop in the same cycle SHALL leave level unchanged.
REQ-031 Pointers SHALL wrap modulo DEPTH, with level as the sole full/empty discriminator.

Reset
REQ-032 rst=1 SHALL immediately force: state IDLE, level 0, pointers 0, tag_cnt 0, pw_start 0, res_valid 0, res_data 0, res_tag 0.
REQ-033 Reset mid-operation SHALL discard queued and in-flight requests; the exponentiator shares rst, so no result is pending after release.

Structure
REQ-034 A shared package pow_pkg SHALL hold the FSM state enum, the request struct {x[15:0], n[7:0], tag}, and the width constants X_W=16 and N_W=8.
REQ-035 The FIFO SHALL be a sub-module req_fifo (parameterised DEPTH, payload type), instantiated once.

Verification
REQ-036 The bench instantiates the team's 16-bit start/ready exponentiator behind pow_dispatcher, with a scoreboard comparing against x^n mod 65536.
REQ-037 Single request: x=3, n=4 with res_ready=1 -> exactly one pw_start pulse, res_data=81, res_tag=0.
REQ-038 Boundary exponents: (2,0), (2,15), (2,16), (0,0) -> 1, 32768, 0, 1 in order, tags 0..3.
REQ-039 Full FIFO: 6 back-to-back pushes with res_ready=0 -> in_ready low once level=4; the extra requests wait; no request is lost or reordered after res_ready rises.
REQ-040 Back-pressure: hold res_ready=0 for 20 cycles in HOLD -> res_data/res_tag stable and no pw_start issued during the hold.
REQ-041 Reset mid-BUSY (x=7, n=200): assert rst -> all outputs at reset values; a following request 5^3 returns 125 with tag 0.
REQ-042 Tag wrap: 257 sequential requests -> the 257th carries res_tag=0.
